// File: rtl/sd_cmd_issuer_pkg.sv
// Shared definitions for the SD command issuer: sdc_controller register map,
// CMD_EVENT_STATUS bit positions, response/transfer encodings, issuer FSM
// states and the COMMAND register word builder.
package sd_bus_pkg;

  localparam logic [7:0] SDC_ADDR_ARGUMENT         = 8'h00;
  localparam logic [7:0] SDC_ADDR_COMMAND          = 8'h04;
  localparam logic [7:0] SDC_ADDR_RESPONSE_0       = 8'h08;
  localparam logic [7:0] SDC_ADDR_RESPONSE_1       = 8'h0C;
  localparam logic [7:0] SDC_ADDR_RESPONSE_2       = 8'h10;
  localparam logic [7:0] SDC_ADDR_RESPONSE_3       = 8'h14;
  localparam logic [7:0] SDC_ADDR_CMD_EVENT_STATUS = 8'h34;

  localparam int unsigned CMD_EVENT_CC   = 0;
  localparam int unsigned CMD_EVENT_EI   = 1;
  localparam int unsigned CMD_EVENT_CTE  = 2;
  localparam int unsigned CMD_EVENT_CCRC = 3;
  localparam int unsigned CMD_EVENT_CIE  = 4;

  localparam logic [1:0] RSP_TYPE_NONE       = 2'b00;
  localparam logic [1:0] RSP_TYPE_SHORT      = 2'b01;
  localparam logic [1:0] RSP_TYPE_LONG       = 2'b10;
  localparam logic [1:0] RSP_TYPE_SHORT_BUSY = 2'b11;

  localparam logic [1:0] XFER_NONE  = 2'b00;
  localparam logic [1:0] XFER_READ  = 2'b01;
  localparam logic [1:0] XFER_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_ARG,
    S_POLL_RD,
    S_POLL_WAIT,
    S_RD_RSP,
    S_CLR,
    S_DONE
  } issuer_state_e;

  function automatic logic [31:0] sd_cmd_word(input logic [5:0] cmd,
                                              input logic [1:0] xfer,
                                              input logic       idx_chk,
                                              input logic       crc_chk,
                                              input logic [1:0] rsp_type);
    return {18'd0, cmd, 1'b0, xfer, idx_chk, crc_chk, 1'b0, rsp_type};
  endfunction

endpackage

// File: rtl/sd_cmd_issuer_if.sv
// Wishbone master/slave bundle between the SD command issuer and the
// sdc_controller register slave. Directions are named from the master side.
interface sd_cmd_issuer_if;
  logic [7:0]  adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (output adr, dat_o, sel, we, cyc, stb, input dat_i, ack);
  modport slave  (input adr, dat_o, sel, we, cyc, stb, output dat_i, ack);
endinterface

// File: rtl/sd_cmd_issuer_wb_access.sv
// sd_wb_access: single-transaction Wishbone engine. A start request while the
// bus is idle launches one registered cycle; the cycle is held until ack is
// sampled, then dropped, and done pulses for one clock with the read data.
module sd_wb_access
  import sd_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [7:0]             adr,
  input  logic                   we,
  input  logic [31:0]            wdat,
  output logic                   done,
  output logic [31:0]            rdat,
  sd_cmd_issuer_if.master        wb
);

  logic        cyc_q;
  logic        we_q;
  logic [7:0]  adr_q;
  logic [31:0] dat_q;

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel   = '1;

  // Launch on start, hold until ack, drop the cycle and pulse done.
  // start is ignored during the done pulse so the sequencer can keep it
  // asserted for the whole state without retriggering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      done  <= 1'b0;
      rdat  <= '0;
    end else begin
      done <= 1'b0;
      if (cyc_q) begin
        if (wb.ack) begin
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
          adr_q <= '0;
          dat_q <= '0;
          rdat  <= wb.dat_i;
          done  <= 1'b1;
        end
      end else if (start && !done) begin
        cyc_q <= 1'b1;
        we_q  <= we;
        adr_q <= adr;
        dat_q <= wdat;
      end
    end
  end

endmodule

// File: rtl/sd_cmd_issuer.sv
// sd_cmd_issuer: runs one SD command on the sdc_controller per request:
// COMMAND write, ARGUMENT write, CMD_EVENT_STATUS polling, response readout,
// status clear. Define SD_CMD_LONG_RSP_EN to read all four response
// registers for 136-bit responses; otherwise only RESPONSE_0 is read.
module sd_cmd_issuer
  import sd_bus_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned POLL_LIMIT    = 65535
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [5:0]             req_cmd,
  input  logic [31:0]            req_arg,
  input  logic [1:0]             req_rsp_type,
  input  logic                   req_crc_chk,
  input  logic                   req_idx_chk,
  input  logic [1:0]             req_xfer,
  output logic                   rsp_valid,
  output logic [5:0]             rsp_status,
  output logic [127:0]           rsp_data,
  output logic                   busy,
  sd_cmd_issuer_if.master        wb
);

`ifdef SD_CMD_LONG_RSP_EN
  localparam bit LONG_RSP_EN = 1'b1;
`else
  localparam bit LONG_RSP_EN = 1'b0;
`endif

  issuer_state_e    state, state_nxt;
  logic [31:0]      cmd_word_q;
  logic [31:0]      arg_q;
  logic [1:0]       rsp_type_q;
  logic [15:0]      poll_cnt;
  logic [15:0]      wait_cnt;
  logic [1:0]       rsp_idx;
  logic [3:0][31:0] rsp_words;

  logic             acc_start;
  logic [7:0]       acc_adr;
  logic             acc_we;
  logic [31:0]      acc_wdat;
  logic             acc_done;
  logic [31:0]      acc_rdat;

  logic             accept;
  logic [4:0]       poll_status;
  logic [15:0]      poll_cnt_inc;
  logic             poll_timeout;
  logic             rsp_more;

  assign req_ready    = (state == S_IDLE);
  assign busy         = ~req_ready;
  assign rsp_valid    = (state == S_DONE);
  assign rsp_data     = rsp_words;
  assign accept       = req_valid && req_ready;
  assign poll_status  = acc_rdat[CMD_EVENT_CIE:CMD_EVENT_CC];
  assign poll_cnt_inc = poll_cnt + 16'd1;
  assign poll_timeout = (poll_status == '0) && (poll_cnt_inc == 16'(POLL_LIMIT));
  assign rsp_more     = LONG_RSP_EN && (rsp_type_q == RSP_TYPE_LONG) && (rsp_idx != 2'd3);

  sd_wb_access u_access (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (acc_start),
    .adr     (acc_adr),
    .we      (acc_we),
    .wdat    (acc_wdat),
    .done    (acc_done),
    .rdat    (acc_rdat),
    .wb      (wb)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and bus-access request decode.
  always_comb begin
    state_nxt = state;
    acc_start = 1'b0;
    acc_adr   = '0;
    acc_we    = 1'b0;
    acc_wdat  = '0;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_WR_CMD;
      S_WR_CMD: begin
        acc_start = 1'b1;
        acc_adr   = SDC_ADDR_COMMAND;
        acc_we    = 1'b1;
        acc_wdat  = cmd_word_q;
        if (acc_done) state_nxt = S_WR_ARG;
      end
      S_WR_ARG: begin
        acc_start = 1'b1;
        acc_adr   = SDC_ADDR_ARGUMENT;
        acc_we    = 1'b1;
        acc_wdat  = arg_q;
        if (acc_done) state_nxt = S_POLL_RD;
      end
      S_POLL_RD: begin
        acc_start = 1'b1;
        acc_adr   = SDC_ADDR_CMD_EVENT_STATUS;
        if (acc_done) begin
          if (poll_status != '0)
            state_nxt = (rsp_type_q == RSP_TYPE_NONE) ? S_CLR : S_RD_RSP;
          else if (poll_timeout)
            state_nxt = S_CLR;
          else
            state_nxt = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (wait_cnt == 16'(POLL_INTERVAL - 1)) state_nxt = S_POLL_RD;
      S_RD_RSP: begin
        acc_start = 1'b1;
        acc_adr   = SDC_ADDR_RESPONSE_0 + {4'd0, rsp_idx, 2'b00};
        if (acc_done && !rsp_more) state_nxt = S_CLR;
      end
      S_CLR: begin
        acc_start = 1'b1;
        acc_adr   = SDC_ADDR_CMD_EVENT_STATUS;
        acc_we    = 1'b1;
        if (acc_done) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, poll/wait counters and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_word_q <= '0;
      arg_q      <= '0;
      rsp_type_q <= '0;
      poll_cnt   <= '0;
      wait_cnt   <= '0;
      rsp_idx    <= '0;
      rsp_status <= '0;
      rsp_words  <= '0;
    end else begin
      wait_cnt <= (state == S_POLL_WAIT) ? wait_cnt + 16'd1 : '0;
      if (accept) begin
        cmd_word_q <= sd_cmd_word(req_cmd, req_xfer, req_idx_chk, req_crc_chk, req_rsp_type);
        arg_q      <= req_arg;
        rsp_type_q <= req_rsp_type;
        poll_cnt   <= '0;
        rsp_idx    <= '0;
        rsp_status <= '0;
        rsp_words  <= '0;
      end
      if (state == S_POLL_RD && acc_done) begin
        poll_cnt        <= poll_cnt_inc;
        rsp_status[4:0] <= poll_status;
        if (poll_timeout) rsp_status[5] <= 1'b1;
      end
      if (state == S_RD_RSP && acc_done) begin
`ifdef SD_CMD_LONG_RSP_EN
        rsp_words[rsp_idx] <= acc_rdat;
        rsp_idx            <= rsp_idx + 2'd1;
`else
        rsp_words[0] <= acc_rdat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Directed testbench for sd_cmd_issuer with a Wishbone slave model that has a
// programmable ack delay and a CMD_EVENT_STATUS script (N zero reads, then a
// fixed value). Every completed bus access is logged for sequence checks.
module tb_sd_cmd_issuer;
  import sd_bus_pkg::*;

  localparam int unsigned PI = 4;
  localparam int unsigned PL = 4;
  localparam int unsigned LOGSZ = 256;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_cmd;
  logic [31:0]  req_arg;
  logic [1:0]   req_rsp_type;
  logic         req_crc_chk;
  logic         req_idx_chk;
  logic [1:0]   req_xfer;
  logic         rsp_valid;
  logic [5:0]   rsp_status;
  logic [127:0] rsp_data;
  logic         busy;

  sd_cmd_issuer_if wb();

  sd_cmd_issuer #(.POLL_INTERVAL(PI), .POLL_LIMIT(PL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_arg      (req_arg),
    .req_rsp_type (req_rsp_type),
    .req_crc_chk  (req_crc_chk),
    .req_idx_chk  (req_idx_chk),
    .req_xfer     (req_xfer),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .wb           (wb)
  );

  always #5 clk = ~clk;

  // Slave model configuration (written by the test tasks only)
  int unsigned ack_dly    = 0;
  int unsigned stat_zeros = 0;
  int unsigned stat_base  = 0;
  int unsigned log_base   = 0;
  logic [31:0] stat_val   = 32'h1;
  logic [31:0] r_word [4];

  // Slave model state (written by the model process only)
  int unsigned ack_cnt    = 0;
  int unsigned stat_reads = 0;
  int unsigned cyc_n      = 0;
  int unsigned log_n      = 0;
  logic        log_we  [LOGSZ];
  logic [7:0]  log_adr [LOGSZ];
  logic [31:0] log_dat [LOGSZ];
  int unsigned log_t   [LOGSZ];

  logic [31:0] bfm_rdat;
  int unsigned errors = 0;
  int unsigned checks = 0;

  assign wb.ack   = wb.cyc && wb.stb && (ack_cnt == ack_dly);
  assign wb.dat_i = bfm_rdat;

  always_comb begin
    bfm_rdat = 32'hBAD0_0000;
    case (wb.adr)
      SDC_ADDR_CMD_EVENT_STATUS: bfm_rdat = ((stat_reads - stat_base) < stat_zeros) ? 32'h0 : stat_val;
      SDC_ADDR_RESPONSE_0:       bfm_rdat = r_word[0];
      SDC_ADDR_RESPONSE_1:       bfm_rdat = r_word[1];
      SDC_ADDR_RESPONSE_2:       bfm_rdat = r_word[2];
      SDC_ADDR_RESPONSE_3:       bfm_rdat = r_word[3];
      default:                   bfm_rdat = 32'hBAD0_0000;
    endcase
  end

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (wb.cyc && !wb.ack) ack_cnt <= ack_cnt + 1;
    else                   ack_cnt <= 0;
    if (wb.cyc && wb.stb && wb.ack) begin
      if (log_n < LOGSZ) begin
        log_we[log_n]  <= wb.we;
        log_adr[log_n] <= wb.adr;
        log_dat[log_n] <= wb.we ? wb.dat_o : wb.dat_i;
        log_t[log_n]   <= cyc_n;
      end
      log_n <= log_n + 1;
      if (!wb.we && wb.adr == SDC_ADDR_CMD_EVENT_STATUS) stat_reads <= stat_reads + 1;
    end
  end

  function automatic logic [40:0] ent(input int unsigned i);
    if (i >= LOGSZ) return 'x;
    return {log_we[i], log_adr[i], log_dat[i]};
  endfunction

  task automatic prep(input int unsigned dly, input int unsigned zeros, input logic [31:0] val);
    @(negedge clk);
    ack_dly    = dly;
    stat_zeros = zeros;
    stat_val   = val;
    stat_base  = stat_reads;
    log_base   = log_n;
  endtask

  // Present one request, wait for acceptance, scramble the inputs, wait for rsp_valid.
  task automatic issue(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] rt,
                       input logic crc, input logic idx, input logic [1:0] xf, output bit ok);
    bit acc;
    acc = 0;
    ok  = 0;
    req_cmd = cmd; req_arg = arg; req_rsp_type = rt;
    req_crc_chk = crc; req_idx_chk = idx; req_xfer = xf;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin acc = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd = 6'h3F; req_arg = 32'hFFFF_FFFF; req_rsp_type = 2'b11;
    req_crc_chk = 1'b0; req_idx_chk = 1'b0; req_xfer = 2'b11;
    if (!acc) return;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_cmd = '0; req_arg = '0; req_rsp_type = '0;
    req_crc_chk = 1'b0; req_idx_chk = 1'b0; req_xfer = '0;
    r_word[0] = '0; r_word[1] = '0; r_word[2] = '0; r_word[3] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_handshake got=%b exp=100", {req_ready, busy, rsp_valid});
    end
    checks++;
    if ({wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_o} !== 43'd0) begin
      errors++; $display("FAIL reset_wb_outputs got=%h exp=0", {wb.cyc, wb.stb, wb.we, wb.adr, wb.dat_o});
    end
    checks++;
    if (wb.sel !== 4'hF) begin errors++; $display("FAIL reset_sel got=%h exp=f", wb.sel); end
    checks++;
    if ({rsp_status, rsp_data} !== 134'd0) begin
      errors++; $display("FAIL reset_results got=%h/%h exp=0", rsp_status, rsp_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_cmd0;
    bit ok;
    logic [40:0] exp_q[$];
    prep(0, 0, 32'h1);
    issue(6'd0, 32'h0, RSP_TYPE_NONE, 1'b0, 1'b0, XFER_NONE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd0_done got=timeout exp=rsp_valid"); end
    checks++;
    if (rsp_status !== 6'h01) begin errors++; $display("FAIL cmd0_status got=%h exp=01", rsp_status); end
    checks++;
    if (rsp_data !== 128'd0) begin errors++; $display("FAIL cmd0_data got=%h exp=0", rsp_data); end
    exp_q = '{{1'b1, 8'h04, 32'h0}, {1'b1, 8'h00, 32'h0}, {1'b0, 8'h34, 32'h1}, {1'b1, 8'h34, 32'h0}};
    checks++;
    if (log_n - log_base != exp_q.size()) begin
      errors++; $display("FAIL cmd0_access_count got=%0d exp=%0d", log_n - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ent(log_base + i) !== exp_q[i]) begin
        errors++; $display("FAIL cmd0_access%0d got=%h exp=%h", i, ent(log_base + i), exp_q[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_status !== 6'h01) begin
      errors++; $display("FAIL cmd0_pulse_hold got=%b/%h exp=0/01", rsp_valid, rsp_status);
    end
  endtask

  task automatic test_cmd8_poll;
    bit ok;
    logic [40:0] exp_q[$];
    r_word[0] = 32'h0000_01AA;
    prep(1, 3, 32'h1);
    issue(6'd8, 32'h1AA, RSP_TYPE_SHORT, 1'b1, 1'b1, XFER_NONE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd8_done got=timeout exp=rsp_valid"); end
    checks++;
    if (rsp_status !== 6'h01) begin errors++; $display("FAIL cmd8_limit_read_success got=%h exp=01", rsp_status); end
    checks++;
    if (rsp_data !== 128'h1AA) begin errors++; $display("FAIL cmd8_data got=%h exp=1aa", rsp_data); end
    exp_q = '{{1'b1, 8'h04, 32'h819}, {1'b1, 8'h00, 32'h1AA},
              {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h1},
              {1'b0, 8'h08, 32'h1AA}, {1'b1, 8'h34, 32'h0}};
    checks++;
    if (log_n - log_base != exp_q.size()) begin
      errors++; $display("FAIL cmd8_access_count got=%0d exp=%0d", log_n - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ent(log_base + i) !== exp_q[i]) begin
        errors++; $display("FAIL cmd8_access%0d got=%h exp=%h", i, ent(log_base + i), exp_q[i]);
      end
    end
    for (int i = 3; i < 6; i++) begin
      checks++;
      if (log_t[log_base + i] - log_t[log_base + i - 1] < PI) begin
        errors++; $display("FAIL cmd8_poll_spacing%0d got=%0d exp>=%0d", i,
                           log_t[log_base + i] - log_t[log_base + i - 1], PI);
      end
    end
  endtask

  task automatic test_long_rsp;
    bit ok;
    logic [40:0] exp_q[$];
    logic [127:0] exp_data;
    r_word[0] = 32'h11; r_word[1] = 32'h22; r_word[2] = 32'h33; r_word[3] = 32'h44;
    prep(2, 0, 32'h1);
    issue(6'd2, 32'h0, RSP_TYPE_LONG, 1'b1, 1'b0, XFER_NONE, ok);
`ifdef SD_CMD_LONG_RSP_EN
    exp_data = 128'h00000044_00000033_00000022_00000011;
    exp_q = '{{1'b1, 8'h04, 32'h20A}, {1'b1, 8'h00, 32'h0}, {1'b0, 8'h34, 32'h1},
              {1'b0, 8'h08, 32'h11}, {1'b0, 8'h0C, 32'h22}, {1'b0, 8'h10, 32'h33}, {1'b0, 8'h14, 32'h44},
              {1'b1, 8'h34, 32'h0}};
`else
    exp_data = 128'h11;
    exp_q = '{{1'b1, 8'h04, 32'h20A}, {1'b1, 8'h00, 32'h0}, {1'b0, 8'h34, 32'h1},
              {1'b0, 8'h08, 32'h11}, {1'b1, 8'h34, 32'h0}};
`endif
    checks++;
    if (!ok) begin errors++; $display("FAIL cmd2_done got=timeout exp=rsp_valid"); end
    checks++;
    if (rsp_data !== exp_data) begin errors++; $display("FAIL cmd2_data got=%h exp=%h", rsp_data, exp_data); end
    checks++;
    if (log_n - log_base != exp_q.size()) begin
      errors++; $display("FAIL cmd2_access_count got=%0d exp=%0d", log_n - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ent(log_base + i) !== exp_q[i]) begin
        errors++; $display("FAIL cmd2_access%0d got=%h exp=%h", i, ent(log_base + i), exp_q[i]);
      end
    end
  endtask

  task automatic test_poll_timeout;
    bit ok;
    logic [40:0] exp_q[$];
    prep(3, 1000, 32'h1);
    issue(6'd55, 32'hCAFE_0001, RSP_TYPE_SHORT, 1'b0, 1'b0, XFER_NONE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done got=timeout exp=rsp_valid"); end
    checks++;
    if (rsp_status !== 6'h20) begin errors++; $display("FAIL timeout_status got=%h exp=20", rsp_status); end
    checks++;
    if (rsp_data !== 128'd0) begin errors++; $display("FAIL timeout_data got=%h exp=0", rsp_data); end
    exp_q = '{{1'b1, 8'h04, 32'h3701}, {1'b1, 8'h00, 32'hCAFE_0001},
              {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h0}, {1'b0, 8'h34, 32'h0},
              {1'b1, 8'h34, 32'h0}};
    checks++;
    if (log_n - log_base != exp_q.size()) begin
      errors++; $display("FAIL timeout_access_count got=%0d exp=%0d", log_n - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ent(log_base + i) !== exp_q[i]) begin
        errors++; $display("FAIL timeout_access%0d got=%h exp=%h", i, ent(log_base + i), exp_q[i]);
      end
    end
  endtask

  task automatic test_error_status;
    bit ok;
    logic [40:0] exp_q[$];
    r_word[0] = 32'hDEAD_BEEF;
    prep(1, 0, 32'h5);
    issue(6'd17, 32'h0000_0200, RSP_TYPE_SHORT, 1'b1, 1'b1, XFER_READ, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL errstat_done got=timeout exp=rsp_valid"); end
    checks++;
    if (rsp_status !== 6'h05) begin errors++; $display("FAIL errstat_status got=%h exp=05", rsp_status); end
    checks++;
    if (rsp_data !== 128'hDEAD_BEEF) begin errors++; $display("FAIL errstat_data got=%h exp=deadbeef", rsp_data); end
    exp_q = '{{1'b1, 8'h04, 32'h1139}, {1'b1, 8'h00, 32'h200}, {1'b0, 8'h34, 32'h5},
              {1'b0, 8'h08, 32'hDEAD_BEEF}, {1'b1, 8'h34, 32'h0}};
    checks++;
    if (log_n - log_base != exp_q.size()) begin
      errors++; $display("FAIL errstat_access_count got=%0d exp=%0d", log_n - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ent(log_base + i) !== exp_q[i]) begin
        errors++; $display("FAIL errstat_access%0d got=%h exp=%h", i, ent(log_base + i), exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    prep(0, 0, 32'h1);
    req_cmd = 6'd0; req_arg = 32'h0; req_rsp_type = RSP_TYPE_NONE;
    req_crc_chk = 1'b0; req_idx_chk = 1'b0; req_xfer = XFER_NONE;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_done got=timeout exp=rsp_valid"); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_status !== 6'h01) begin
      errors++; $display("FAIL b2b_idle_gap got=%b/%h exp=1/01", req_ready, rsp_status);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || rsp_status !== 6'h00) begin
      errors++; $display("FAIL b2b_reaccept_clear got=%b/%h exp=1/00", busy, rsp_status);
    end
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok || rsp_status !== 6'h01) begin
      errors++; $display("FAIL b2b_second got=%b/%h exp=1/01", ok, rsp_status);
    end
    checks++;
    if (log_n - log_base != 8) begin
      errors++; $display("FAIL b2b_access_count got=%0d exp=8", log_n - log_base);
    end
  endtask

  task automatic test_reset_midcycle;
    bit ok;
    bit seen;
    prep(3, 1000, 32'h1);
    req_cmd = 6'd1; req_arg = 32'h40FF_8000; req_rsp_type = RSP_TYPE_SHORT;
    req_crc_chk = 1'b0; req_idx_chk = 1'b0; req_xfer = XFER_NONE;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wb.cyc && !wb.we && wb.adr == SDC_ADDR_CMD_EVENT_STATUS) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_reach_poll got=timeout exp=status_read"); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wb.cyc, wb.stb, wb.we} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_bus_drop got=%b exp=000", {wb.cyc, wb.stb, wb.we});
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ready got=%b/%b exp=1/0", req_ready, rsp_valid);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready got=%b exp=1", req_ready); end
    prep(0, 0, 32'h1);
    issue(6'd0, 32'h0, RSP_TYPE_NONE, 1'b0, 1'b0, XFER_NONE, ok);
    checks++;
    if (!ok || rsp_status !== 6'h01) begin
      errors++; $display("FAIL rst_mid_next_req got=%b/%h exp=1/01", ok, rsp_status);
    end
    checks++;
    if (log_n - log_base != 4) begin
      errors++; $display("FAIL rst_mid_next_count got=%0d exp=4", log_n - log_base);
    end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8_poll();
    test_long_rsp();
    test_poll_timeout();
    test_error_status();
    test_back_to_back();
    test_reset_midcycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
